// File: rtl/expected_in_accumulator_pkg.sv
// Shared definitions for the back-propagation path.
// zero2one_t is the fixed-point code of a value in [0,1].
package expected_in_accumulator_pkg;

  localparam int ZW = 8;

  typedef logic [ZW-1:0] zero2one_t;

  localparam zero2one_t Z2O_MAX = '1;

endpackage

// File: rtl/expected_in_accumulator_div.sv
// Serial restoring divider by a constant divisor.
// One load cycle, then one quotient bit per cycle, MSB first.
module seq_udiv_const #(
  parameter int SW = 13,
  parameter int M  = 18
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic [SW-1:0] i_dividend,
  output logic          o_busy,
  output logic          o_done,
  output logic [SW-1:0] o_quot
);

  localparam int CW = $clog2(SW + 1);
  localparam logic [SW:0] DIV = (SW + 1)'(M);

  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_q;
  logic [SW-1:0] r_rem;
  logic [SW:0]   w_trial;
  logic          w_ge;
  logic [SW-1:0] w_rem_nx;

  // Trial subtraction of one restoring step.
  always_comb begin
    w_trial  = {r_rem, r_q[SW-1]};
    w_ge     = (w_trial >= DIV);
    w_rem_nx = w_ge ? SW'(w_trial - DIV)
                    : w_trial[SW-1:0];
  end

  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == CW'(1));
  assign o_quot = {r_q[SW-2:0], w_ge};

  // Dividend shifts out of r_q as quotient bits shift in.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_q   <= '0;
      r_rem <= '0;
    end else if (i_start && !o_busy) begin
      r_cnt <= CW'(SW);
      r_q   <= i_dividend;
      r_rem <= '0;
    end else if (o_busy) begin
      r_cnt <= r_cnt - CW'(1);
      r_q   <= o_quot;
      r_rem <= w_rem_nx;
    end
  end

endmodule

// File: rtl/expected_in_accumulator.sv
// Averages M back-propagated expected_in rows column-wise.
// Columns are divided serially by one shared divider.
module expected_in_accumulator
  import expected_in_accumulator_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 18
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                row_valid,
  input  zero2one_t [N-1:0]   row,
  output logic                row_ready,
  output logic                avg_valid,
  output zero2one_t [N-1:0]   avg,
  input  logic                avg_ready,
  output logic                busy
);

  localparam int SW  = ZW + $clog2(M);
  localparam int RW  = $clog2(M);
  localparam int CLW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ACCUM,
    DIVIDE,
    HOLD
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [RW-1:0]   r_rcnt;
  logic [CLW-1:0]  r_col;
  logic [SW-1:0]   r_sum [N];

  logic            w_xfer;
  logic            w_last_row;
  logic            w_start;
  logic            w_div_busy;
  logic            w_done;
  logic            w_last_col;
  logic            w_hs;
  logic [SW-1:0]   w_quot;

  assign w_xfer     = row_valid && row_ready;
  assign w_last_row = w_xfer && (r_rcnt == RW'(M - 1));
  assign w_start    = (r_state == DIVIDE) && !w_div_busy;
  assign w_last_col = w_done && (r_col == CLW'(N - 1));
  assign w_hs       = avg_valid && avg_ready;

  seq_udiv_const #(
    .SW (SW),
    .M  (M)
  ) u_div (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_start    (w_start),
    .i_dividend (r_sum[r_col]),
    .o_busy     (w_div_busy),
    .o_done     (w_done),
    .o_quot     (w_quot)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nx = r_state;
    row_ready  = 1'b0;
    avg_valid  = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      ACCUM: begin
        row_ready = 1'b1;
        busy      = (r_rcnt != '0);
        if (w_last_row) w_state_nx = DIVIDE;
      end
      DIVIDE: begin
        if (w_last_col) w_state_nx = HOLD;
      end
      HOLD: begin
        avg_valid = 1'b1;
        if (avg_ready) w_state_nx = ACCUM;
      end
      default: w_state_nx = ACCUM;
    endcase
  end

  // Row accumulation, column walk and result capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rcnt <= '0;
      r_col  <= '0;
      avg    <= '0;
      for (int c = 0; c < N; c++) r_sum[c] <= '0;
    end else begin
      if (w_xfer) begin
        for (int c = 0; c < N; c++)
          r_sum[c] <= r_sum[c] + SW'(row[c]);
        r_rcnt <= w_last_row ? '0
                             : r_rcnt + RW'(1);
      end
      if (w_last_row) r_col <= '0;
      if (w_done) begin
        avg[r_col] <= zero2one_t'(w_quot);
        r_col <= w_last_col ? '0
                            : r_col + CLW'(1);
      end
      if (w_hs) begin
        for (int c = 0; c < N; c++) r_sum[c] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_expected_in_accumulator.sv
// Bench for expected_in_accumulator.
// Expected averages come from plain column sums of the rows sent.
module tb_expected_in_accumulator;
  import expected_in_accumulator_pkg::*;

  localparam int N    = 16;
  localparam int M    = 18;
  localparam int SWM  = ZW + $clog2(M);
  localparam int LAT  = N * (SWM + 1);
  localparam int MAXC = (1 << ZW) - 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              row_valid = 1'b0;
  logic              avg_ready = 1'b0;
  zero2one_t [N-1:0] row;
  logic              row_ready;
  logic              avg_valid;
  logic              busy;
  zero2one_t [N-1:0] avg;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned rows_m [M][N];
  int unsigned exp_avg [N];

  expected_in_accumulator #(
    .N (N),
    .M (M)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row_valid (row_valid),
    .row       (row),
    .row_ready (row_ready),
    .avg_valid (avg_valid),
    .avg       (avg),
    .avg_ready (avg_ready),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic fill_const(input int unsigned v);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        rows_m[r][c] = v;
  endtask

  task automatic compute_exp;
    for (int c = 0; c < N; c++) begin
      int unsigned s;
      s = 0;
      for (int r = 0; r < M; r++) s += rows_m[r][c];
      exp_avg[c] = (s / M) % (MAXC + 1);
    end
  endtask

  function automatic logic [255:0] exp_vec();
    zero2one_t [N-1:0] e;
    for (int c = 0; c < N; c++) e[c] = zero2one_t'(exp_avg[c]);
    return 256'(e);
  endfunction

  task automatic send_rows(input int cnt, input bit keep_valid);
    for (int r = 0; r < cnt; r++) begin
      row_valid = 1'b1;
      for (int c = 0; c < N; c++)
        row[c] = zero2one_t'(rows_m[r][c]);
      step;
    end
    if (!keep_valid) row_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int cyc;
    cyc = 0;
    compute_exp();
    chk({tag, "_busy"}, 256'(busy), 256'(1));
    chk({tag, "_rdy"}, 256'(row_ready), 256'(0));
    while (!avg_valid && cyc < 4 * LAT) begin
      step;
      cyc++;
    end
    chk({tag, "_lat"}, 256'(cyc), 256'(LAT));
    for (int c = 0; c < N; c++)
      chk($sformatf("%s_avg%0d", tag, c),
          256'(avg[c]), 256'(exp_avg[c]));
  endtask

  task automatic handshake(input string tag);
    avg_ready = 1'b1;
    step;
    avg_ready = 1'b0;
    chk({tag, "_hs_valid"}, 256'(avg_valid), 256'(0));
    chk({tag, "_hs_rdy"}, 256'(row_ready), 256'(1));
    chk({tag, "_hs_busy"}, 256'(busy), 256'(0));
    chk({tag, "_hs_keep"}, 256'(avg), exp_vec());
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 256'(row_ready), 256'(1));
    chk({tag, "_valid"}, 256'(avg_valid), 256'(0));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_avg"}, 256'(avg), 256'(0));
  endtask

  initial begin
    row = '0;
    #1;
    chk_reset("rst");
    step;
    step;
    reset_n = 1'b1;

    fill_const(5);
    send_rows(M, 1'b0);
    wait_result("all5");
    handshake("all5");

    fill_const(0);
    for (int r = 0; r < M; r++) rows_m[r][0] = r;
    send_rows(M, 1'b0);
    wait_result("ramp");
    handshake("ramp");

    fill_const(0);
    rows_m[7][3] = 18;
    send_rows(M, 1'b0);
    wait_result("c3_18");
    handshake("c3_18");

    fill_const(0);
    rows_m[11][3] = 17;
    send_rows(M, 1'b0);
    wait_result("c3_17");
    handshake("c3_17");

    fill_const(MAXC);
    send_rows(M, 1'b0);
    wait_result("max");
    for (int i = 0; i < 10; i++) begin
      row_valid = i[0];
      row = {N{zero2one_t'(9)}};
      step;
      chk("stall_valid", 256'(avg_valid), 256'(1));
      chk("stall_rdy", 256'(row_ready), 256'(0));
      chk("stall_avg", 256'(avg), exp_vec());
    end
    row_valid = 1'b0;
    handshake("max");

    fill_const(3);
    send_rows(9, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_reset("rst_acc");
    step;
    reset_n = 1'b1;

    fill_const(6);
    send_rows(M, 1'b0);
    repeat (50) step;
    chk("mid_div_busy", 256'(busy), 256'(1));
    reset_n = 1'b0;
    #1;
    chk_reset("rst_div");
    step;
    reset_n = 1'b1;

    fill_const(2);
    send_rows(M, 1'b0);
    wait_result("two");
    handshake("two");

    fill_const(4);
    send_rows(M, 1'b1);
    wait_result("b2b4");
    handshake("b2b4");
    fill_const(7);
    send_rows(M, 1'b0);
    wait_result("b2b7");
    handshake("b2b7");

    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          rows_m[r][c] = $urandom_range(0, MAXC);
      send_rows(M, 1'b0);
      wait_result($sformatf("rnd%0d", k));
      repeat ($urandom_range(0, 4)) step;
      handshake($sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
